// File: rtl/bin2cdu_if.sv
// bin2cdu_if: start/done handshake and digit outputs of the binary-to-digit converter.
interface bin2cdu_if;
  logic       start;
  logic [9:0] bin;
  logic       busy;
  logic       done;
  logic [4:0] u;
  logic [4:0] d;
  logic [4:0] c;
  modport master (output start, bin, input busy, done, u, d, c);
  modport slave (input start, bin, output busy, done, u, d, c);
endinterface

// File: rtl/bin2cdu.sv
// bin2cdu: iterative double-dabble binary to display-digit codes (0-9, 16 blank, 17 error).
// BIN2CDU_BLANK_EN enables leading-zero blanking of the hundreds and tens digits.
module bin2cdu (
  input logic      clk,
  input logic      rst,
  bin2cdu_if.slave io
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q;
  logic [21:0] sr_q;
  logic [21:0] sr_d;
  logic [3:0]  cnt_q;
  logic        ovf_q;
  logic        done_q;
  logic [4:0]  u_q, d_q, c_q;
  logic [4:0]  u_d, d_d, c_d;
  logic [3:0]  h_a, t_a, n_a;
  always_comb begin
    h_a = sr_q[21:18] >= 4'd5 ? sr_q[21:18] + 4'd3 : sr_q[21:18];
    t_a = sr_q[17:14] >= 4'd5 ? sr_q[17:14] + 4'd3 : sr_q[17:14];
    n_a = sr_q[13:10] >= 4'd5 ? sr_q[13:10] + 4'd3 : sr_q[13:10];
    sr_d = {h_a, t_a, n_a, sr_q[9:0]} << 1;
    u_d = ovf_q ? 5'd17 : {1'b0, sr_q[13:10]};
`ifdef BIN2CDU_BLANK_EN
    d_d = ovf_q ? 5'd17 : sr_q[21:14] == 8'd0 ? 5'd16 : {1'b0, sr_q[17:14]};
    c_d = ovf_q ? 5'd17 : sr_q[21:18] == 4'd0 ? 5'd16 : {1'b0, sr_q[21:18]};
`else
    d_d = ovf_q ? 5'd17 : {1'b0, sr_q[17:14]};
    c_d = ovf_q ? 5'd17 : {1'b0, sr_q[21:18]};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      u_q     <= 5'd16;
      d_q     <= 5'd16;
      c_q     <= 5'd16;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ovf_q <= io.bin > 10'd999;
          if (io.start) begin
            sr_q    <= {12'b0, io.bin};
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) state_q <= DONE;
        end
        default: begin
          u_q     <= u_d;
          d_q     <= d_d;
          c_q     <= c_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign io.busy = state_q != IDLE;
  assign io.done = done_q;
  assign io.u    = u_q;
  assign io.d    = d_q;
  assign io.c    = c_q;
endmodule

// File: tb/tb_bin2cdu.sv
// tb_bin2cdu: directed scoreboard bench for bin2cdu; honours BIN2CDU_BLANK_EN like the design.
module tb_bin2cdu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  logic [14:0] sb[$];
  bin2cdu_if io ();
  bin2cdu dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  function automatic logic [14:0] model(int v);
    logic [4:0] c, d, u;
    int h, t;
    if (v > 999) return {5'd17, 5'd17, 5'd17};
    h = v / 100;
    t = (v / 10) % 10;
    c = 5'(h);
    d = 5'(t);
    u = 5'(v % 10);
`ifdef BIN2CDU_BLANK_EN
    if (h == 0) c = 5'd16;
    if (h == 0 && t == 0) d = 5'd16;
`endif
    return {c, d, u};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag);
    int lat;
    logic [14:0] e;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (io.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    e = sb.size() > 0 ? sb.pop_front() : 15'h7fff;
    chk({tag, " latency"}, lat, 11);
    chk({tag, " busy_at_done"}, io.busy, 0);
    chk({tag, " c"}, io.c, e[14:10]);
    chk({tag, " d"}, io.d, e[9:5]);
    chk({tag, " u"}, io.u, e[4:0]);
  endtask
  task automatic launch(input int v);
    io.start = 1'b1;
    io.bin = 10'(v);
    sb.push_back(model(v));
    @(negedge clk);
    io.start = 1'b0;
    io.bin = 10'($urandom);
    chk("busy_after_accept", io.busy, 1);
  endtask
  task automatic conv(input int v, input string tag);
    launch(v);
    wait_done(tag);
  endtask
  initial begin
    int pulses;
    io.start = 1'b0;
    io.bin = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle done", io.done, 0);
      chk("idle busy", io.busy, 0);
    end
    chk("reset c", io.c, 16);
    chk("reset d", io.d, 16);
    chk("reset u", io.u, 16);
    conv(347, "bin347");
    conv(7, "bin7");
    conv(0, "bin0");
    conv(999, "bin999");
    conv(1000, "bin1000");
    conv(1023, "bin1023");
    @(negedge clk);
    chk("done one cycle", io.done, 0);
    chk("held c", io.c, 17);
    launch(123);
    repeat (3) @(negedge clk);
    io.start = 1'b1;
    io.bin = 10'd456;
    @(negedge clk);
    io.start = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      @(negedge clk);
      if (io.done === 1'b1) break;
    end
    chk("ignored start early done", io.done, 0);
    for (int k = 0; k < 20; k++) begin
      if (io.done === 1'b1) break;
      @(negedge clk);
    end
    begin
      logic [14:0] e;
      e = sb.pop_front();
      chk("bin123 c", io.c, e[14:10]);
      chk("bin123 d", io.d, e[9:5]);
      chk("bin123 u", io.u, e[4:0]);
    end
    conv(456, "bin456");
    launch(500);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk("abort c", io.c, 16);
    chk("abort d", io.d, 16);
    chk("abort u", io.u, 16);
    chk("abort busy", io.busy, 0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (io.done === 1'b1) pulses++;
    end
    chk("abort done pulses", pulses, 0);
    conv(61, "bin61");
    rst = 1'b1;
    io.start = 1'b1;
    io.bin = 10'd5;
    @(negedge clk);
    rst = 1'b0;
    io.start = 1'b0;
    chk("reset wins busy", io.busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
